sprite_line_shifter: RTL and testbench

//  Parametrised sprite-row serialiser; successor to the single-word 2-bit shifter.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_line_shifter_if.sv | 15 +
 rtl/sprite_word_shreg.sv | 74 +++++++
 rtl/sprite_line_shifter.sv | 159 +++++++++++++++
 tb/tb_sprite_line_shifter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_pkg.sv
// Shared types and sizing helpers for the sprite line shifter and the
// sprite-memory fetch block that feeds it.
//  - state_t      : row FSM states (IDLE, FILL, SHIFT)
//  - PIX_PER_WORD : pixels per word for the default 2-bit / 32-bit build
//  - cnt_w()      : counter width able to hold the values 0..n-1
package sprite_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SHIFT
    } state_t;

    localparam int PIX_W_DEF          = 2;
    localparam int DATA_W_DEF         = 32;
    localparam int WORDS_PER_LINE_DEF = 2;
    localparam int PIX_PER_WORD       = DATA_W_DEF / PIX_W_DEF;

    // Width of a counter running over 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sprite_line_shifter_if.sv
// Word handshake between the sprite-memory fetch logic (master) and the
// line shifter (slave).
//  in_valid : master -> slave, in_data holds a valid word
//  in_data  : master -> slave, packed pixel word
//  in_ready : slave -> master, slave accepts a word this cycle
interface sprite_line_shifter_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sprite_word_shreg.sv
// One sprite word held as a load/shift register with pixel select.
//  clk, reset : system clock, synchronous active-high reset
//  clear      : flush the register (row restart); wins over load
//  load       : capture load_data and restart the pixel count
//  shift      : consume the currently presented pixel
//  flip       : 1 = present pixels MSB-first, 0 = LSB-first
//  pix        : currently presented pixel
//  empty      : no pixel held
//  last       : the presented pixel is the final one of this word
module sprite_word_shreg
    import sprite_pkg::*;
#(
    parameter int PIX_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift,
    input  logic              flip,
    output logic [PIX_W-1:0]  pix,
    output logic              empty,
    output logic              last
);
    localparam int PPW    = DATA_W / PIX_W;
    localparam int PCNT_W = cnt_w(PPW);

    logic [DATA_W-1:0] data_q, data_d;
    logic [PCNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              full_q, full_d;

    // The presented pixel always sits at the end the register drains from.
    assign pix   = flip ? data_q[DATA_W-1 -: PIX_W] : data_q[PIX_W-1:0];
    assign empty = !full_q;
    assign last  = full_q && (pix_cnt_q == PCNT_W'(PPW - 1));

    // A load on the cycle the last pixel drains replaces the word outright,
    // which is what lets back-to-back words stream without a gap.
    always_comb begin
        data_d    = data_q;
        pix_cnt_d = pix_cnt_q;
        full_d    = full_q;
        if (clear) begin
            data_d    = '0;
            pix_cnt_d = '0;
            full_d    = 1'b0;
        end else if (load) begin
            data_d    = load_data;
            pix_cnt_d = '0;
            full_d    = 1'b1;
        end else if (shift && full_q) begin
            data_d    = flip ? (data_q << PIX_W) : (data_q >> PIX_W);
            pix_cnt_d = pix_cnt_q + PCNT_W'(1);
            if (last) begin
                full_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q    <= '0;
            pix_cnt_q <= '0;
            full_q    <= 1'b0;
        end else begin
            data_q    <= data_d;
            pix_cnt_q <= pix_cnt_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: rtl/sprite_line_shifter.sv
// Sprite-row serialiser: accepts WORDS_PER_LINE packed words per row over a
// valid/ready handshake and emits one PIX_W pixel per pix_en, with one
// pending word prefetched so the row streams without gaps.
// Optional feature macro: SPRITE_HFLIP_EN adds the hflip port (mirror row).
//  clk, reset : system clock, synchronous active-high reset
//  start      : begin a new row, aborting any row in progress
//  in_if      : word handshake (slave side)
//  pix_en     : advance one pixel
//  hflip      : mirror select, sampled at start (SPRITE_HFLIP_EN only)
//  pix_out    : registered pixel, 0 when none emitted
//  pix_valid  : pix_out holds a real sprite pixel
//  line_done  : pulse alongside the row's last valid pixel
//  underrun   : pulse when pix_en arrives while busy with nothing buffered
//  busy       : row in progress
module sprite_line_shifter
    import sprite_pkg::*;
#(
    parameter int PIX_W          = 2,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    sprite_line_shifter_if.slave in_if,
    input  logic                 pix_en,
`ifdef SPRITE_HFLIP_EN
    input  logic                 hflip,
`endif
    output logic [PIX_W-1:0]     pix_out,
    output logic                 pix_valid,
    output logic                 line_done,
    output logic                 underrun,
    output logic                 busy
);
    localparam int WCNT_W = cnt_w(WORDS_PER_LINE + 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] pend_q, pend_d;
    logic              pend_full_q, pend_full_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic              flip_q, flip_d;

    logic [PIX_W-1:0]  pix_out_q, pix_out_d;
    logic              pix_valid_q, pix_valid_d;
    logic              line_done_q, line_done_d;
    logic              underrun_q, underrun_d;

    logic [PIX_W-1:0]  act_pix;
    logic              act_empty, act_last;
    logic              xfer, xfer_to_act, emit, drain, done, act_load;
    logic [DATA_W-1:0] act_load_data;

    assign busy           = (state_q != IDLE);
    assign in_if.in_ready = busy && !pend_full_q
                            && (word_cnt_q < WCNT_W'(WORDS_PER_LINE));

    assign xfer        = in_if.in_valid && in_if.in_ready;
    assign emit        = pix_en && !act_empty;
    assign drain       = emit && act_last;
    // The row ends only once every word has arrived and nothing waits in pending.
    assign done        = drain && !pend_full_q
                         && (word_cnt_q == WCNT_W'(WORDS_PER_LINE));
    assign xfer_to_act = xfer && (act_empty || drain);
    // in_ready requires pending empty, so a transfer and a pending move never coincide.
    assign act_load      = xfer_to_act || (drain && pend_full_q);
    assign act_load_data = pend_full_q ? pend_q : in_if.in_data;

    sprite_word_shreg #(
        .PIX_W  (PIX_W),
        .DATA_W (DATA_W)
    ) u_active (
        .clk       (clk),
        .reset     (reset),
        .clear     (start),
        .load      (act_load),
        .load_data (act_load_data),
        .shift     (emit),
        .flip      (flip_q),
        .pix       (act_pix),
        .empty     (act_empty),
        .last      (act_last)
    );

    // Row FSM, pending word and word counter; start overrides everything
    // after the current pixel has been taken.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        word_cnt_d  = word_cnt_q;
        flip_d      = flip_q;
        case (state_q)
            IDLE:    state_d = IDLE;
            FILL:    if (act_load) state_d = SHIFT;
            SHIFT:   if (done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (xfer) begin
            word_cnt_d = word_cnt_q + WCNT_W'(1);
            if (!xfer_to_act) begin
                pend_d      = in_if.in_data;
                pend_full_d = 1'b1;
            end
        end else if (drain && pend_full_q) begin
            pend_d      = '0;
            pend_full_d = 1'b0;
        end
        if (start) begin
            state_d     = FILL;
            pend_d      = '0;
            pend_full_d = 1'b0;
            word_cnt_d  = '0;
`ifdef SPRITE_HFLIP_EN
            flip_d      = hflip;
`else
            flip_d      = 1'b0;
`endif
        end
    end

    // Registered pixel outputs default to transparent.
    always_comb begin
        pix_out_d   = emit ? act_pix : '0;
        pix_valid_d = emit;
        line_done_d = done;
        underrun_d  = pix_en && busy && act_empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            word_cnt_q  <= '0;
            flip_q      <= 1'b0;
            pix_out_q   <= '0;
            pix_valid_q <= 1'b0;
            line_done_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            word_cnt_q  <= word_cnt_d;
            flip_q      <= flip_d;
            pix_out_q   <= pix_out_d;
            pix_valid_q <= pix_valid_d;
            line_done_q <= line_done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign pix_out   = pix_out_q;
    assign pix_valid = pix_valid_q;
    assign line_done = line_done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_sprite_line_shifter.sv
// Self-checking bench for sprite_line_shifter (default 2-bit / 32-bit / 2-word
// build). Reference model: a queue of the row's remaining pixels plus a
// count of accepted words; with SPRITE_HFLIP_EN defined the mirror case runs too.
module tb_sprite_line_shifter;

    localparam int PIX_W = 2;
    localparam int DATA_W = 32;
    localparam int WPL = 2;
    localparam int PPW = DATA_W / PIX_W;

    logic clk = 1'b0;
    logic reset, start, pix_en, hflip;
    logic [PIX_W-1:0] pix_out;
    logic pix_valid, line_done, underrun, busy;

    sprite_line_shifter_if #(.DATA_W(DATA_W)) ifc ();

    sprite_line_shifter #(
        .PIX_W          (PIX_W),
        .DATA_W         (DATA_W),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_if     (ifc.slave),
        .pix_en    (pix_en),
`ifdef SPRITE_HFLIP_EN
        .hflip     (hflip),
`endif
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .line_done (line_done),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nBad = 0;

    // Reference model state
    logic [PIX_W-1:0] mQ[$];
    int mWords;
    bit mBusy;
    bit mFlip;

    // Per-cycle results: {ready before edge, busy, valid, done, underrun, pix}
    logic [6:0] expVec, obsVec;
    bit xferObs;

    task automatic applyStimulus(input bit rst, input bit st, input bit iv,
                                 input logic [DATA_W-1:0] d, input bit pe);
        bit emit, doneE, unrE, rdyE, xfer, obsRdy;
        logic [PIX_W-1:0] pixE;
        reset = rst;
        start = st;
        ifc.in_valid = iv;
        ifc.in_data = d;
        pix_en = pe;
        #1;
        obsRdy = ifc.in_ready;
        rdyE = mBusy && (mQ.size() <= PPW) && (mWords < WPL);
        emit = pe && (mQ.size() > 0);
        pixE = emit ? mQ[0] : '0;
        doneE = emit && (mQ.size() == 1) && (mWords == WPL);
        unrE = pe && mBusy && (mQ.size() == 0);
        xfer = iv && rdyE;
        xferObs = iv && obsRdy;
        if (rst) begin
            mQ.delete();
            mWords = 0;
            mBusy = 0;
            mFlip = 0;
            emit = 0; pixE = '0; doneE = 0; unrE = 0;
        end else begin
            if (emit) void'(mQ.pop_front());
            if (xfer) begin
                for (int i = 0; i < PPW; i++)
                    mQ.push_back(mFlip ? d[DATA_W-PIX_W-PIX_W*i +: PIX_W] : d[PIX_W*i +: PIX_W]);
                mWords++;
            end
            if (doneE) mBusy = 0;
            if (st) begin
                mQ.delete();
                mWords = 0;
                mBusy = 1;
`ifdef SPRITE_HFLIP_EN
                mFlip = hflip;
`else
                mFlip = 0;
`endif
            end
        end
        @(posedge clk);
        #1;
        expVec = {rdyE, mBusy, emit, doneE, unrE, pixE};
        obsVec = {obsRdy, busy, pix_valid, line_done, underrun, pix_out};
    endtask

    task automatic test_reset();
        applyStimulus(1, 0, 0, '0, 0);
        applyStimulus(1, 0, 0, '0, 0);
        nChecks++;
        if (obsVec !== expVec) begin
            nBad++; $display("[TB] FAIL reset_model got=%b want=%b", obsVec, expVec);
        end
        nChecks++;
        if ({busy, ifc.in_ready, pix_valid, pix_out, line_done, underrun} !== 7'b0) begin
            nBad++; $display("[TB] FAIL reset_idle got=%b want=0", {busy, ifc.in_ready, pix_valid, pix_out, line_done, underrun});
        end
        // Mid-row reset with a word pending
        applyStimulus(0, 1, 0, '0, 0);
        applyStimulus(0, 0, 1, $urandom, 0);
        applyStimulus(0, 0, 1, $urandom, 1);
        applyStimulus(0, 0, 0, '0, 1);
        applyStimulus(1, 0, 0, '0, 1);
        nChecks++;
        if ({busy, ifc.in_ready, pix_valid, pix_out} !== 5'b0) begin
            nBad++; $display("[TB] FAIL reset_midrow got=%b want=00000", {busy, ifc.in_ready, pix_valid, pix_out});
        end
        nChecks++;
        if (obsVec !== expVec) begin
            nBad++; $display("[TB] FAIL reset_midrow_model got=%b want=%b", obsVec, expVec);
        end
    endtask

    task automatic test_basic_row();
        int doneCnt = 0;
        logic [PIX_W-1:0] want;
        applyStimulus(0, 0, 0, '0, 0);
        applyStimulus(0, 1, 0, '0, 0);
        applyStimulus(0, 0, 1, 32'hFFFF_FFFF, 0);
        applyStimulus(0, 0, 1, 32'h0000_0001, 0);
        for (int k = 0; k < 32; k++) begin
            applyStimulus(0, 0, 0, '0, 1);
            want = (k < 16) ? 2'd3 : ((k == 16) ? 2'd1 : 2'd0);
            nChecks++;
            if (pix_valid !== 1'b1 || pix_out !== want || line_done !== (k == 31)) begin
                nBad++; $display("[TB] FAIL basic_pix k=%0d got=%b/%0d/%b want=1/%0d/%b", k, pix_valid, pix_out, line_done, want, k == 31);
            end
            nChecks++;
            if (obsVec !== expVec) begin
                nBad++; $display("[TB] FAIL basic_model k=%0d got=%b want=%b", k, obsVec, expVec);
            end
            if (line_done) doneCnt++;
        end
        applyStimulus(0, 0, 0, '0, 1);
        nChecks++;
        if (busy !== 1'b0 || pix_valid !== 1'b0 || underrun !== 1'b0 || doneCnt != 1) begin
            nBad++; $display("[TB] FAIL basic_end got=busy%b valid%b unr%b done%0d want=0/0/0/1", busy, pix_valid, underrun, doneCnt);
        end
    endtask

    task automatic test_underrun();
        int unr = 0, vld = 0, dn = 0;
        applyStimulus(0, 1, 0, '0, 0);
        applyStimulus(0, 0, 1, $urandom, 0);
        for (int c = 1; c <= 60 && dn == 0; c++) begin
            applyStimulus(0, 0, (c == 20), $urandom, 1);
            unr += underrun; vld += pix_valid; dn += line_done;
            nChecks++;
            if (obsVec !== expVec) begin
                nBad++; $display("[TB] FAIL underrun_model c=%0d got=%b want=%b", c, obsVec, expVec);
            end
            if (c >= 17 && c <= 20) begin
                nChecks++;
                if (underrun !== 1'b1 || pix_valid !== 1'b0) begin
                    nBad++; $display("[TB] FAIL underrun_pulse c=%0d got=%b%b want=10", c, underrun, pix_valid);
                end
            end
        end
        nChecks++;
        if (unr != 4 || vld != 32 || dn != 1) begin
            nBad++; $display("[TB] FAIL underrun_totals got=%0d/%0d/%0d want=4/32/1", unr, vld, dn);
        end
    endtask

    task automatic test_abort();
        int dn = 0;
        logic [DATA_W-1:0] nw;
        applyStimulus(0, 1, 0, '0, 0);
        applyStimulus(0, 0, 1, $urandom, 0);
        applyStimulus(0, 0, 1, $urandom, 0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, '0, 1);
            dn += line_done;
        end
        applyStimulus(0, 1, 0, '0, 1);
        dn += line_done;
        nw = $urandom;
        applyStimulus(0, 0, 1, nw, 1);
        dn += line_done;
        applyStimulus(0, 0, 0, '0, 1);
        nChecks++;
        if (pix_valid !== 1'b1 || pix_out !== nw[1:0] || dn != 0) begin
            nBad++; $display("[TB] FAIL abort_first got=%b/%0d done%0d want=1/%0d done0", pix_valid, pix_out, dn, nw[1:0]);
        end
        dn = 0;
        for (int c = 0; c < 40 && dn == 0; c++) begin
            applyStimulus(0, 0, (c == 0), $urandom, 1);
            dn += line_done;
            nChecks++;
            if (obsVec !== expVec) begin
                nBad++; $display("[TB] FAIL abort_model c=%0d got=%b want=%b", c, obsVec, expVec);
            end
        end
        nChecks++;
        if (dn != 1) begin
            nBad++; $display("[TB] FAIL abort_done got=%0d want=1", dn);
        end
    endtask

    task automatic test_back_to_back();
        int hs = 0, vld = 0, firstV = -1, doneAt = -1;
        applyStimulus(0, 1, 0, '0, 0);
        for (int c = 0; c < 60 && doneAt < 0; c++) begin
            applyStimulus(0, 0, 1, $urandom, 1);
            hs += xferObs;
            vld += pix_valid;
            if (pix_valid && firstV < 0) firstV = c;
            if (line_done) doneAt = c;
            nChecks++;
            if (obsVec !== expVec) begin
                nBad++; $display("[TB] FAIL b2b_model c=%0d got=%b want=%b", c, obsVec, expVec);
            end
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 0, 1, $urandom, 0);
            hs += xferObs;
        end
        nChecks++;
        if (hs != 2 || vld != 32 || doneAt - firstV != 31) begin
            nBad++; $display("[TB] FAIL b2b_stream got=hs%0d vld%0d span%0d want=hs2 vld32 span31", hs, vld, doneAt - firstV);
        end
    endtask

    task automatic test_random();
        bit st, rst;
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            st = (!mBusy && $urandom_range(0, 3) == 0) || ($urandom_range(0, 99) == 0);
            hflip = $urandom_range(0, 1);
            applyStimulus(rst, st, $urandom_range(0, 1), $urandom, $urandom_range(0, 3) != 0);
            nChecks++;
            if (obsVec !== expVec) begin
                nBad++; $display("[TB] FAIL random_model c=%0d got=%b want=%b", c, obsVec, expVec);
            end
        end
        hflip = 0;
    endtask

`ifdef SPRITE_HFLIP_EN
    task automatic test_hflip();
        hflip = 1;
        applyStimulus(0, 1, 0, '0, 0);
        hflip = 0;
        applyStimulus(0, 0, 1, 32'h4000_0000, 0);
        applyStimulus(0, 0, 1, 32'h0000_0000, 0);
        for (int k = 0; k < 32; k++) begin
            applyStimulus(0, 0, 0, '0, 1);
            nChecks++;
            if (pix_valid !== 1'b1 || pix_out !== ((k == 0) ? 2'd1 : 2'd0)) begin
                nBad++; $display("[TB] FAIL hflip_pix k=%0d got=%b/%0d want=1/%0d", k, pix_valid, pix_out, (k == 0) ? 1 : 0);
            end
        end
    endtask
`endif

    initial begin
        reset = 1; start = 0; pix_en = 0; hflip = 0;
        ifc.in_valid = 0; ifc.in_data = '0;
        mWords = 0; mBusy = 0; mFlip = 0;
        test_reset();
        test_basic_row();
        test_underrun();
        test_abort();
        test_back_to_back();
`ifdef SPRITE_HFLIP_EN
        test_hflip();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule
